// File: rtl/ahb_lite_master_if_if.sv
// Request/response and AHB-Lite bus signals for ahb_lite_master_if.
// The master modport is the design's view; slave is the core + bus side.
interface ahb_lite_master_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Core load/store request and response
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_func3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;

    // AHB-Lite bus
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [3:0]        hprot;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        input  req_valid, req_write, req_func3, req_addr, req_wdata,
        input  hrdata, hready, hresp,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output htrans, haddr, hwrite, hsize, hprot, hwdata
    );

    modport slave (
        output req_valid, req_write, req_func3, req_addr, req_wdata,
        output hrdata, hready, hresp,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  htrans, haddr, hwrite, hsize, hprot, hwdata
    );
endinterface

// File: rtl/ahb_lite_master_if.sv
// Single-outstanding AHB-Lite master for the core load/store unit.
// One request at a time: region/alignment decode on acceptance, then an
// address phase, a data phase with wait states, two-cycle error handling,
// a wait-state timeout, and a one-cycle response pulse.
module ahb_lite_master_if #(
    parameter int               ADDR_W  = 32,
    parameter int               DATA_W  = 32,
    parameter int               TAG_W   = 8,
    parameter logic [TAG_W-1:0] ROM_TAG = 8'hA0,
    parameter logic [TAG_W-1:0] RAM_TAG = 8'hB0,
    parameter int               TIMEOUT = 64
) (
    input logic                 hclk,
    input logic                 hreset,
    ahb_lite_master_if_if.master bus
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR_WAIT,
        S_RESP,
        S_RESP_ERR
    } state_t;

    state_t            r_state;
    logic [1:0]        r_htrans;
    logic [ADDR_W-1:0] r_haddr;
    logic              r_hwrite;
    logic [2:0]        r_hsize;
    logic [3:0]        r_hprot;
    logic [DATA_W-1:0] r_hwdata;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [DATA_W-1:0] r_resp_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_func3;
    logic [DATA_W-1:0] r_wdata;

    logic [TAG_W-1:0]  w_tag;
    logic              w_is_rom;
    logic              w_is_ram;
    logic              w_f3_ok;
    logic              w_dec_err;
    logic              w_misalign;
    logic [DATA_W-1:0] w_wdata_rep;
    logic [DATA_W-1:0] w_lane;
    logic [DATA_W-1:0] w_rdata_ext;
    logic              w_timeout;

    assign w_tag = bus.req_addr[ADDR_W-1 -: TAG_W];

    // Region, width-code and alignment checks on the incoming request
    always_comb begin
        w_is_rom   = (w_tag == ROM_TAG);
        w_is_ram   = (w_tag == RAM_TAG);
        w_f3_ok    = (bus.req_func3 == 3'b000) || (bus.req_func3 == 3'b001) ||
                     (bus.req_func3 == 3'b010) || (bus.req_func3 == 3'b100) ||
                     (bus.req_func3 == 3'b101);
        w_dec_err  = !(w_is_rom || w_is_ram) || (w_is_rom && bus.req_write) || !w_f3_ok;
        w_misalign = ((bus.req_func3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_func3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end

    // Replicate store data across every byte lane so the slave can pick any lane
    always_comb begin
        w_wdata_rep = '0;
        for (int i = 0; i < LANES; i++) begin
            case (r_func3[1:0])
                2'b00:   w_wdata_rep[i*8 +: 8] = r_wdata[7:0];
                2'b01:   w_wdata_rep[i*8 +: 8] = r_wdata[(i%2)*8 +: 8];
                default: w_wdata_rep[i*8 +: 8] = r_wdata[(i%4)*8 +: 8];
            endcase
        end
    end

    // Pick the addressed little-endian lane and extend it to the full width
    always_comb begin
        w_lane = bus.hrdata >> {r_haddr[OFF_W-1:0], 3'b000};
        case (r_func3)
            3'b000:  w_rdata_ext = DATA_W'($signed(w_lane[7:0]));
            3'b001:  w_rdata_ext = DATA_W'($signed(w_lane[15:0]));
            3'b100:  w_rdata_ext = DATA_W'(w_lane[7:0]);
            3'b101:  w_rdata_ext = DATA_W'(w_lane[15:0]);
            default: w_rdata_ext = DATA_W'(w_lane[31:0]);
        endcase
    end

    // Count of wait cycles reaches TIMEOUT on this one; TIMEOUT=0 never fires
    assign w_timeout = (TIMEOUT != 0) && (int'(r_cnt) == TIMEOUT - 1);

    // Transfer sequencer; every bus and response output is a register here
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state      <= S_IDLE;
            r_htrans     <= HTRANS_IDLE;
            r_haddr      <= '0;
            r_hwrite     <= 1'b0;
            r_hsize      <= 3'b010;
            r_hprot      <= 4'b0000;
            r_hwdata     <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_cnt        <= '0;
            r_func3      <= '0;
            r_wdata      <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_func3     <= bus.req_func3;
                        r_wdata     <= bus.req_wdata;
                        r_cnt       <= '0;
                        if (w_dec_err || w_misalign) begin
                            // Rejected locally: the bus never sees it
                            r_state      <= S_RESP_ERR;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state  <= S_ADDR;
                            r_htrans <= HTRANS_NONSEQ;
                            r_haddr  <= bus.req_addr;
                            r_hwrite <= bus.req_write;
                            r_hsize  <= {1'b0, bus.req_func3[1:0]};
                            r_hprot  <= {3'b000, w_is_ram};
                        end
                    end
                end
                S_ADDR: begin
                    if (bus.hready) begin
                        r_state  <= S_DATA;
                        r_htrans <= HTRANS_IDLE;
                        r_hwdata <= r_hwrite ? w_wdata_rep : '0;
                        r_cnt    <= '0;
                    end
                end
                S_DATA: begin
                    if (bus.hready) begin
                        // hresp with hready here is a protocol violation; still an error
                        r_cnt        <= '0;
                        r_resp_valid <= 1'b1;
                        if (bus.hresp) begin
                            r_state    <= S_RESP_ERR;
                            r_resp_err <= 1'b1;
                        end else begin
                            r_state      <= S_RESP;
                            r_resp_rdata <= r_hwrite ? '0 : w_rdata_ext;
                        end
                    end else if (bus.hresp) begin
                        r_state <= S_ERR_WAIT;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state      <= S_RESP_ERR;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ERR_WAIT: begin
                    r_htrans <= HTRANS_IDLE;
                    if (bus.hready) begin
                        r_state      <= S_RESP_ERR;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_cnt        <= '0;
                    end
                end
                S_RESP, S_RESP_ERR: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_cnt       <= '0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_htrans    <= HTRANS_IDLE;
                    r_req_ready <= 1'b1;
                    r_cnt       <= '0;
                end
            endcase
        end
    end

    assign bus.htrans     = r_htrans;
    assign bus.haddr      = r_haddr;
    assign bus.hwrite     = r_hwrite;
    assign bus.hsize      = r_hsize;
    assign bus.hprot      = r_hprot;
    assign bus.hwdata     = r_hwdata;
    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
endmodule

// File: tb/tb_ahb_lite_master_if.sv
// Self-checking bench for ahb_lite_master_if: directed scenarios plus
// randomized transfers compared against a rule-level reference model.
module tb_ahb_lite_master_if;
    localparam int TMO = 4;

    logic hclk = 1'b0;
    logic hreset;
    int   n_chk  = 0;
    int   n_fail = 0;

    ahb_lite_master_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_lite_master_if #(
        .ADDR_W(32), .DATA_W(32), .TAG_W(8),
        .ROM_TAG(8'hA0), .RAM_TAG(8'hB0), .TIMEOUT(TMO)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        bit          got;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          nonseq;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic [3:0]  hprot;
        logic        hwrite;
        logic [31:0] hwdata;
        bit          wd_stable;
        bit          idle_ok;
        bit          ready_after;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic bit m_bad(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        int tag  = int'(addr >> 24);
        bit f_ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        int sz   = 1 << (f3 % 4);
        if (tag != 'hA0 && tag != 'hB0) return 1;
        if (wr && tag == 'hA0) return 1;
        if (!f_ok) return 1;
        return (addr % sz) != 0;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (addr % 4));
        int sz = 1 << (f3 % 4);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_hwdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 % 4 == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3 % 4 == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // mode: 0 ok, 1 two-cycle error, 2 hang (timeout), 3 error with hready
    function automatic int m_lat(input bit bad, input int aw, input int dw, input int mode);
        if (bad) return 1;
        case (mode)
            0:       return (aw + 1) + (dw + 1) + 1;
            1:       return (aw + 1) + (dw + 2) + 1;
            2:       return (aw + 1) + TMO + 1;
            default: return (aw + 1) + (dw + 1) + 1;
        endcase
    endfunction

    // ---------------- bus-side driver (no checking) ----------------
    // Starts and ends on a falling edge.
    task automatic run_xfer(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int aw, input int dw, input int mode, output obs_t o);
        int awl = aw;
        int d   = 0;
        bit dph = 0;
        o = '{default: 0};
        o.wd_stable = 1;
        o.idle_ok   = 1;
        for (int k = 0; k < 20 && bus.req_ready !== 1'b1; k++) @(negedge hclk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_func3 = f3;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge hclk);
        @(negedge hclk);
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        bus.req_addr  = $urandom;
        for (int k = 1; k <= 100; k++) begin
            if (bus.resp_valid === 1'b1) begin
                o.got   = 1;
                o.lat   = k;
                o.err   = bus.resp_err;
                o.rdata = bus.resp_rdata;
                bus.hready = 1'b1;
                bus.hresp  = 1'b0;
                @(negedge hclk);
                o.ready_after = (bus.req_ready === 1'b1) && (bus.resp_valid === 1'b0);
                break;
            end
            bus.hrdata = $urandom;
            if (!dph) begin
                bus.hresp = 1'b0;
                if (bus.htrans === 2'b10) begin
                    o.nonseq++;
                    o.haddr  = bus.haddr;
                    o.hsize  = bus.hsize;
                    o.hprot  = bus.hprot;
                    o.hwrite = bus.hwrite;
                    if (awl > 0) begin bus.hready = 1'b0; awl--; end
                    else begin bus.hready = 1'b1; dph = 1; end
                end else begin
                    bus.hready = 1'b1;
                end
            end else begin
                if (bus.htrans !== 2'b00) o.idle_ok = 0;
                if (d == 0) o.hwdata = bus.hwdata;
                else if (bus.hwdata !== o.hwdata) o.wd_stable = 0;
                case (mode)
                    0: begin
                        bus.hresp  = 1'b0;
                        bus.hready = (d >= dw);
                        if (d >= dw) bus.hrdata = rd;
                    end
                    1: begin
                        bus.hresp  = (d >= dw);
                        bus.hready = (d > dw);
                    end
                    2: begin
                        bus.hresp  = 1'b0;
                        bus.hready = 1'b0;
                    end
                    default: begin
                        bus.hresp  = (d >= dw);
                        bus.hready = (d >= dw);
                    end
                endcase
                d++;
            end
            @(negedge hclk);
        end
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        hreset = 1'b1;
        repeat (3) @(negedge hclk);
        n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got=%0h exp=1", bus.req_ready); end
        n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%0h exp=0", bus.resp_valid); end
        n_chk++; if (bus.htrans !== 2'b00) begin n_fail++; $display("FAIL rst_htrans got=%0h exp=0", bus.htrans); end
        n_chk++; if (bus.hsize !== 3'b010) begin n_fail++; $display("FAIL rst_hsize got=%0h exp=2", bus.hsize); end
        n_chk++; if ({bus.haddr, bus.hwdata, bus.resp_rdata} !== 96'h0) begin n_fail++; $display("FAIL rst_data got=%0h/%0h/%0h exp=0", bus.haddr, bus.hwdata, bus.resp_rdata); end
        n_chk++; if ({bus.hwrite, bus.hprot, bus.resp_err} !== 6'h0) begin n_fail++; $display("FAIL rst_ctrl got=%0h/%0h/%0h exp=0", bus.hwrite, bus.hprot, bus.resp_err); end
        hreset = 1'b0;
        @(negedge hclk);
    endtask

    task automatic test_lw();
        obs_t o;
        run_xfer(1'b0, 3'b010, 32'hB000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, o);
        n_chk++; if (o.lat !== 3) begin n_fail++; $display("FAIL lw_latency got=%0d exp=3", o.lat); end
        n_chk++; if (o.nonseq !== 1) begin n_fail++; $display("FAIL lw_nonseq_cycles got=%0d exp=1", o.nonseq); end
        n_chk++; if (o.hsize !== 3'b010 || o.hprot !== 4'b0001) begin n_fail++; $display("FAIL lw_hsize_hprot got=%0h/%0h exp=2/1", o.hsize, o.hprot); end
        n_chk++; if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0) begin n_fail++; $display("FAIL lw_rdata got=%0h err=%0h exp=deadbeef err=0", o.rdata, o.err); end
        n_chk++; if (!o.ready_after) begin n_fail++; $display("FAIL lw_ready_after got=0 exp=1"); end
    endtask

    task automatic test_lb();
        obs_t o;
        run_xfer(1'b0, 3'b000, 32'hA000_0003, 32'h0, 32'h80FF_FFFF, 0, 0, 0, o);
        n_chk++; if (o.rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_sext got=%0h exp=ffffff80", o.rdata); end
        n_chk++; if (o.hprot !== 4'b0000 || o.hsize !== 3'b000) begin n_fail++; $display("FAIL lb_hprot_hsize got=%0h/%0h exp=0/0", o.hprot, o.hsize); end
        run_xfer(1'b0, 3'b100, 32'hA000_0003, 32'h0, 32'h80FF_FFFF, 0, 0, 0, o);
        n_chk++; if (o.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zext got=%0h exp=80", o.rdata); end
    endtask

    task automatic test_sh();
        obs_t o;
        run_xfer(1'b1, 3'b001, 32'hB000_0002, 32'h0000_1234, 32'h0, 0, 3, 0, o);
        n_chk++; if (o.hwdata !== 32'h1234_1234 || !o.wd_stable) begin n_fail++; $display("FAIL sh_hwdata got=%0h stable=%0d exp=12341234 stable=1", o.hwdata, o.wd_stable); end
        n_chk++; if (o.hsize !== 3'b001 || o.hwrite !== 1'b1) begin n_fail++; $display("FAIL sh_hsize_hwrite got=%0h/%0h exp=1/1", o.hsize, o.hwrite); end
        n_chk++; if (o.lat !== 6 || o.err !== 1'b0 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL sh_resp got=lat%0d err%0h rd%0h exp=lat6 err0 rd0", o.lat, o.err, o.rdata); end
    endtask

    task automatic test_bus_error();
        obs_t o;
        run_xfer(1'b0, 3'b010, 32'hB000_0040, 32'h0, 32'h1111_2222, 0, 0, 1, o);
        n_chk++; if (o.err !== 1'b1 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL buserr_resp got=err%0h rd%0h exp=err1 rd0", o.err, o.rdata); end
        n_chk++; if (!o.idle_ok) begin n_fail++; $display("FAIL buserr_htrans got=nonidle exp=idle"); end
        n_chk++; if (o.lat !== 4 || !o.ready_after) begin n_fail++; $display("FAIL buserr_timing got=lat%0d rdy%0d exp=lat4 rdy1", o.lat, o.ready_after); end
    endtask

    task automatic test_decode_err();
        obs_t o;
        logic [31:0] addrs [3] = '{32'hA000_0000, 32'hC000_0000, 32'hB000_0002};
        logic        wrs   [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_xfer(wrs[i], 3'b010, addrs[i], 32'h5555_AAAA, 32'h0, 0, 0, 0, o);
            n_chk++; if (o.nonseq !== 0 || o.err !== 1'b1 || o.lat !== 1) begin n_fail++; $display("FAIL decode_err_%0d got=ns%0d err%0h lat%0d exp=ns0 err1 lat1", i, o.nonseq, o.err, o.lat); end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_xfer(1'b0, 3'b010, 32'hB000_0100, 32'h0, 32'h0, 0, 0, 2, o);
        n_chk++; if (o.got !== 1 || o.err !== 1'b1 || o.lat !== 1 + TMO + 1) begin n_fail++; $display("FAIL timeout got=got%0d err%0h lat%0d exp=got1 err1 lat%0d", o.got, o.err, o.lat, 1 + TMO + 1); end
    endtask

    task automatic test_reset_mid();
        bit saw_resp = 0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_func3 = 3'b010;
        bus.req_addr  = 32'hB000_0100;
        @(posedge hclk);
        @(negedge hclk);
        bus.req_valid = 1'b0;
        bus.hready    = 1'b0;
        n_chk++; if (bus.htrans !== 2'b10) begin n_fail++; $display("FAIL rstmid_in_addr got=%0h exp=2", bus.htrans); end
        hreset = 1'b1;
        @(negedge hclk);
        hreset = 1'b0;
        bus.hready = 1'b1;
        n_chk++; if (bus.htrans !== 2'b00 || bus.haddr !== 32'h0 || bus.hsize !== 3'b010 || bus.hprot !== 4'h0 || bus.hwrite !== 1'b0 || bus.hwdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_bus got=%0h/%0h/%0h/%0h exp=0/0/2/0", bus.htrans, bus.haddr, bus.hsize, bus.hprot); end
        n_chk++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_resp got=rdy%0h vld%0h exp=rdy1 vld0", bus.req_ready, bus.resp_valid); end
        for (int i = 0; i < 5; i++) begin
            if (bus.resp_valid !== 1'b0) saw_resp = 1;
            @(negedge hclk);
        end
        n_chk++; if (saw_resp) begin n_fail++; $display("FAIL rstmid_no_resp got=1 exp=0"); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [2:0]  vf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [7:0]  tags [3] = '{8'hA0, 8'hB0, 8'hC0};
        for (int n = 0; n < 60; n++) begin
            logic        wr  = 1'($urandom);
            logic [2:0]  f3  = ($urandom_range(0, 3) != 0) ? vf3[$urandom_range(0, 4)] : 3'($urandom);
            int          ts  = $urandom_range(0, 4);
            logic [7:0]  tg  = (ts < 3) ? tags[ts] : ((ts == 3) ? 8'hB0 : 8'($urandom));
            logic [31:0] a   = {tg, 24'($urandom)};
            logic [31:0] wd  = $urandom;
            logic [31:0] rd  = $urandom;
            int          aw  = $urandom_range(0, 2);
            int          dw  = $urandom_range(0, 3);
            int          r   = $urandom_range(0, 9);
            int          md  = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 3 : 2;
            bit          bad;
            logic [31:0] erd;
            if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << (f3 % 4)) - 1);
            bad = m_bad(wr, f3, a);
            erd = (bad || md != 0 || wr) ? 32'h0 : m_rdata(f3, a, rd);
            run_xfer(wr, f3, a, wd, rd, aw, dw, md, o);
            n_chk++; if (o.got !== 1 || o.lat !== m_lat(bad, aw, dw, md)) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, o.lat, m_lat(bad, aw, dw, md)); end
            n_chk++; if (o.err !== (bad || md != 0) || o.rdata !== erd) begin n_fail++; $display("FAIL rnd%0d_resp got=err%0h rd%0h exp=err%0h rd%0h", n, o.err, o.rdata, (bad || md != 0), erd); end
            n_chk++; if (o.nonseq !== (bad ? 0 : aw + 1) || !o.ready_after) begin n_fail++; $display("FAIL rnd%0d_nonseq got=%0d rdy%0d exp=%0d rdy1", n, o.nonseq, o.ready_after, bad ? 0 : aw + 1); end
            if (!bad) begin
                n_chk++; if (o.haddr !== a || o.hsize !== 3'(f3 % 4) || o.hprot !== ((a >> 24) == 'hB0 ? 4'h1 : 4'h0) || o.hwrite !== wr) begin n_fail++; $display("FAIL rnd%0d_addrphase got=%0h/%0h/%0h/%0h exp=%0h/%0h", n, o.haddr, o.hsize, o.hprot, o.hwrite, a, f3 % 4); end
                n_chk++; if (!o.idle_ok) begin n_fail++; $display("FAIL rnd%0d_htrans_data got=nonidle exp=idle", n); end
                if (wr) begin
                    n_chk++; if (o.hwdata !== m_hwdata(f3, wd) || !o.wd_stable) begin n_fail++; $display("FAIL rnd%0d_hwdata got=%0h st%0d exp=%0h", n, o.hwdata, o.wd_stable, m_hwdata(f3, wd)); end
                end
            end
        end
    endtask

    initial begin
        hreset        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_func3 = 3'b000;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.hrdata    = 32'h0;
        bus.hready    = 1'b1;
        bus.hresp     = 1'b0;
        @(negedge hclk);
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_bus_error();
        test_decode_err();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
